// File: rtl/joystick_pkg.sv
// Shared definitions for the joystick sensor pollers: sequencer states,
// per-sample byte count, default register address and axis word width.
package joystick_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2
  } seq_state_t;

  localparam int          AXIS_BYTES        = 6;
  localparam int          AXIS_WIDTH        = 16;
  localparam logic [7:0]  DEFAULT_BASE_ADDR = 8'h32;

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running divider: one-cycle tick every SAMPLE_DIV cycles while enable is
// high; the count is held at zero while enable is low.
module sample_tick_gen #(
  parameter int SAMPLE_DIV = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int CW = $clog2(SAMPLE_DIV);
  localparam logic [CW-1:0] LAST = CW'(SAMPLE_DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (!enable) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  // Gated by enable so dropping enable also cancels a tick due this cycle.
  assign tick = enable && (count == LAST);

endmodule

// File: rtl/axis_sample_sequencer.sv
// Periodic X/Y/Z accelerometer fetch over a req/ack byte-read port; publishes
// only complete samples, with timeout and overrun reported as pulses.
module axis_sample_sequencer
  import joystick_pkg::*;
#(
  parameter int         SAMPLE_DIV = 100000,
  parameter int         TIMEOUT    = 1024,
  parameter logic [7:0] BASE_ADDR  = DEFAULT_BASE_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic        rd_req,
  output logic [7:0]  rd_addr,
  input  logic        rd_ack,
  input  logic [7:0]  rd_data,
  output logic [15:0] data_x,
  output logic [15:0] data_y,
  output logic [15:0] data_z,
  output logic        sample_valid,
  output logic        busy,
  output logic        timeout_err,
  output logic        overrun,
  output logic [1:0]  fsm_state
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);
  localparam logic [2:0]    IDX_LAST  = 3'(AXIS_BYTES - 1);

  seq_state_t    state, state_next;
  logic          tick;
  logic [2:0]    idx;
  logic [2:0]    idx_inc;
  logic [TW-1:0] wait_cnt;
  logic [7:0]    shadow [AXIS_BYTES];
  logic          start, accept, expire, publish;

  sample_tick_gen #(
    .SAMPLE_DIV(SAMPLE_DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .enable(enable),
    .tick  (tick)
  );

  assign idx_inc   = idx + 3'd1;
  assign fsm_state = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // rd_ack only matters in REQ, and it is checked before expiry so a
  // coincident ack wins over the timeout.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    accept     = 1'b0;
    expire     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (tick) begin
          start      = 1'b1;
          state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        if (rd_ack) begin
          accept     = 1'b1;
          state_next = (idx == IDX_LAST) ? ST_IDLE : ST_GAP;
        end else if (wait_cnt == WAIT_LAST) begin
          expire     = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_GAP:  state_next = ST_REQ;
      default: state_next = ST_IDLE;
    endcase
  end

  assign publish = accept && (idx == IDX_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx          <= '0;
      wait_cnt     <= '0;
      rd_addr      <= '0;
      rd_req       <= 1'b0;
      busy         <= 1'b0;
      data_x       <= '0;
      data_y       <= '0;
      data_z       <= '0;
      sample_valid <= 1'b0;
      timeout_err  <= 1'b0;
      overrun      <= 1'b0;
      for (int i = 0; i < AXIS_BYTES; i++) shadow[i] <= '0;
    end else begin
      rd_req       <= (state_next == ST_REQ);
      busy         <= (state_next != ST_IDLE);
      sample_valid <= publish;
      timeout_err  <= expire;
      overrun      <= tick && (state != ST_IDLE);

      // Every REQ is entered from IDLE or GAP, so clearing outside REQ
      // gives each byte a fresh wait budget.
      if (state != ST_REQ)  wait_cnt <= '0;
      else if (!rd_ack)     wait_cnt <= wait_cnt + 1'b1;

      if (start) begin
        idx     <= '0;
        rd_addr <= BASE_ADDR;
      end

      if (accept) begin
        shadow[idx] <= rd_data;
        if (idx != IDX_LAST) begin
          idx     <= idx_inc;
          rd_addr <= BASE_ADDR + {5'd0, idx_inc};
        end
      end

      // The sixth byte is taken straight from rd_data on the publishing edge.
      if (publish) begin
        data_x <= {shadow[1], shadow[0]};
        data_y <= {shadow[3], shadow[2]};
        data_z <= {rd_data, shadow[4]};
      end
    end
  end

endmodule

// File: tb/tb_axis_sample_sequencer.sv
// Bench for axis_sample_sequencer: latency-programmable read slave, expected
// sample queue filled as each fetch is launched and drained on sample_valid.
module tb_axis_sample_sequencer;

  localparam int DIV = 16;
  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        rd_req;
  logic [7:0]  rd_addr;
  logic        rd_ack;
  logic [7:0]  rd_data;
  logic [15:0] data_x, data_y, data_z;
  logic        sample_valid, busy, timeout_err, overrun;
  logic [1:0]  fsm_state;

  axis_sample_sequencer #(
    .SAMPLE_DIV(DIV),
    .TIMEOUT   (TMO),
    .BASE_ADDR (8'h32)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .rd_req      (rd_req),
    .rd_addr     (rd_addr),
    .rd_ack      (rd_ack),
    .rd_data     (rd_data),
    .data_x      (data_x),
    .data_y      (data_y),
    .data_z      (data_z),
    .sample_valid(sample_valid),
    .busy        (busy),
    .timeout_err (timeout_err),
    .overrun     (overrun),
    .fsm_state   (fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // scoreboard state
  logic [47:0] exp_q[$];
  int          lat_q[$];
  logic [47:0] last_good = '0;
  int n_valid = 0, n_to = 0, n_ovr = 0;
  int start_cyc = 0;
  bit prev_busy = 1'b0;

  // slave state
  logic [7:0] mem [6];
  int  slave_lat = 0;
  int  stall_idx = -1;
  bit  spurious  = 1'b0;
  int  slave_idx = 0;
  int  wcnt      = 0;
  bit  acked_prev = 1'b0;
  logic [7:0] prev_addr = '0;

  task automatic monitor_step();
    logic [47:0] e;
    int l;
    if (busy && !prev_busy) start_cyc = cyc;
    prev_busy = busy;
    if (acked_prev) check("gap_after_ack", rd_req, 1'b0);
    if (sample_valid) begin
      n_valid++;
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        l = lat_q.pop_front();
        check("data_x", data_x, e[15:0]);
        check("data_y", data_y, e[31:16]);
        check("data_z", data_z, e[47:32]);
        check("tick_to_valid", cyc - start_cyc + 1, l);
        last_good = e;
      end
    end
    if (timeout_err) begin
      n_to++;
      check("rd_req_at_timeout", rd_req, 1'b0);
      check("timeout_wait_len", wcnt, TMO);
      check("hold_after_timeout", {data_z, data_y, data_x}, last_good);
    end
    if (overrun) n_ovr++;
  endtask

  task automatic slave_step();
    acked_prev = 1'b0;
    if (rd_req) begin
      if (wcnt > 0) check("addr_stable", rd_addr, prev_addr);
      prev_addr = rd_addr;
      if (slave_idx != stall_idx && wcnt == slave_lat) begin
        check("rd_addr", rd_addr, 8'h32 + slave_idx);
        rd_ack  = 1'b1;
        rd_data = mem[slave_idx];
        slave_idx++;
        acked_prev = 1'b1;
        wcnt = 0;
      end else begin
        rd_ack = 1'b0;
        wcnt++;
      end
    end else begin
      wcnt = 0;
      rd_ack  = spurious;
      rd_data = spurious ? 8'hAA : 8'h00;
    end
    if (!busy) slave_idx = 0;
  endtask

  initial begin
    rd_ack  = 1'b0;
    rd_data = '0;
    forever begin
      @(negedge clk);
      monitor_step();
      slave_step();
    end
  end

  // driver: load slave bytes, launch one fetch, wait for its outcome
  task automatic run_fetch(input logic [47:0] bytes, input int lat, input int stall,
                           input bit spur, input bit drop_en, input int exp_ovr);
    int  v0, t0, o0;
    bit  done;
    for (int i = 0; i < 6; i++) mem[i] = bytes[8*i +: 8];
    slave_lat = lat;
    stall_idx = stall;
    spurious  = spur;
    if (stall < 0) begin
      exp_q.push_back({mem[5], mem[4], mem[3], mem[2], mem[1], mem[0]});
      lat_q.push_back(6 * (lat + 1) + 5 + 1);
    end
    v0 = n_valid; t0 = n_to; o0 = n_ovr;
    @(negedge clk); #1;
    enable = 1'b1;
    if (drop_en) begin
      for (int k = 0; k < 100; k++) begin
        @(negedge clk); #1;
        if (busy) break;
      end
      enable = 1'b0;
    end
    done = 1'b0;
    for (int k = 0; k < 800; k++) begin
      @(negedge clk); #1;
      if (n_valid != v0 || n_to != t0) begin
        done = 1'b1;
        break;
      end
    end
    enable = 1'b0;
    check("fetch_done", done, 1'b1);
    check("timeout_count", n_to - t0, (stall >= 0) ? 1 : 0);
    check("valid_count", n_valid - v0, (stall >= 0) ? 0 : 1);
    repeat (3) @(negedge clk);
    #1;
    check("overrun_count", n_ovr - o0, exp_ovr);
    check("idle_after", busy, 1'b0);
    spurious = 1'b0;
  endtask

  task automatic rand_bytes(output logic [47:0] b);
    for (int i = 0; i < 6; i++) b[8*i +: 8] = 8'($urandom_range(0, 255));
  endtask

  initial begin
    logic [47:0] b;
    bit found;
    int k;
    reset  = 1'b1;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rd_req", rd_req, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_data", {data_z, data_y, data_x}, 48'h0);
    check("rst_pulses", {sample_valid, timeout_err, overrun}, 3'b000);
    check("rst_state", fsm_state, 2'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // zero-wait slave with the reference byte pattern
    run_fetch(48'h8000_FFFE_1234, 0, -1, 1'b0, 1'b0, 0);
    check("ref_x", data_x, 16'h1234);
    check("ref_y", data_y, 16'hFFFE);
    check("ref_z", data_z, 16'h8000);

    // 3-cycle latency, enable dropped once the fetch has started
    rand_bytes(b);
    run_fetch(b, 3, -1, 1'b0, 1'b1, 0);

    // byte 3 never acked: timeout, prior sample held
    rand_bytes(b);
    run_fetch(b, 0, 3, 1'b0, 1'b0, 0);

    // restart after timeout, latency 5 with ticks landing while busy
    rand_bytes(b);
    run_fetch(b, 5, -1, 1'b0, 1'b0, 2);

    // spurious acks in IDLE and GAP are ignored
    rand_bytes(b);
    run_fetch(b, 2, -1, 1'b1, 1'b0, 1);

    // ack on the final permitted wait cycle wins over expiry
    rand_bytes(b);
    run_fetch(b, TMO - 1, -1, 1'b0, 1'b0, 3);

    // reset while waiting on byte 4
    rand_bytes(b);
    for (int i = 0; i < 6; i++) mem[i] = b[8*i +: 8];
    slave_lat = 3;
    stall_idx = -1;
    @(negedge clk); #1;
    enable = 1'b1;
    found = 1'b0;
    for (int j = 0; j < 200; j++) begin
      @(posedge clk); #2;
      if (rd_req && !rd_ack && slave_idx == 4) begin
        found = 1'b1;
        break;
      end
    end
    check("reset_window", found, 1'b1);
    reset = 1'b1;
    #1;
    check("midrst_rd_req", rd_req, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_data", {data_z, data_y, data_x}, 48'h0);
    check("midrst_valid", sample_valid, 1'b0);
    check("midrst_addr", rd_addr, 8'h00);
    last_good = '0;
    repeat (3) @(negedge clk);
    rand_bytes(b);
    for (int i = 0; i < 6; i++) mem[i] = b[8*i +: 8];
    slave_lat = 0;
    exp_q.push_back({mem[5], mem[4], mem[3], mem[2], mem[1], mem[0]});
    lat_q.push_back(12);
    @(posedge clk); #2;
    reset = 1'b0;
    found = 1'b0;
    k = 0;
    for (int j = 1; j <= 40; j++) begin
      @(posedge clk); #1;
      if (rd_req) begin
        found = 1'b1;
        k = j;
        break;
      end
    end
    check("first_req_after_reset", k, DIV);
    found = 1'b0;
    for (int j = 0; j < 100; j++) begin
      @(negedge clk); #1;
      if (exp_q.size() == 0) begin
        found = 1'b1;
        break;
      end
    end
    enable = 1'b0;
    check("post_reset_sample", found, 1'b1);
    repeat (20) @(negedge clk);

    check("exp_q_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected < 40000", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axis_sample_sequencer.md
# axis_sample_sequencer

Periodic sampling controller that fetches the three accelerometer axes for the joystick direction classifier. It issues six byte reads over a req/ack register-read port, normally served by the sensor SPI master. It assembles the bytes into signed 16-bit X/Y/Z words and presents them with a one-cycle valid strobe. Timeouts and sample overruns are reported as pulses, so the downstream classifier only ever sees complete, coherent samples.

## Interface
- `SAMPLE_DIV`, default 100000: clk cycles between sample ticks; legal range ≥ 16.
- `TIMEOUT`, default 1024: maximum cycles `rd_req` may wait for `rd_ack` before the sample is abandoned; ≥ 2.
- `BASE_ADDR`, default 8'h32: address of the X low byte. Six consecutive addresses are read: X0, X1, Y0, Y1, Z0, Z1.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high.
- `enable`  in  1  permits sample ticks; when low the tick counter is held at 0.
- `rd_req`  out  1  read request; held high until acked or timed out.
- `rd_addr`  out  8  byte address; stable while `rd_req` is high.
- `rd_ack`  in  1  one-cycle acknowledge; `rd_data` is valid in the same cycle.
- `rd_data`  in  8  read byte.
- `data_x`, `data_y`, `data_z`  out  16 each  signed axis samples, registered.
- `sample_valid`  out  1  one-cycle pulse when all three axes update together.
- `busy`  out  1  high while a sample fetch is in progress (state ≠ IDLE).
- `timeout_err`  out  1  one-cycle pulse when a sample is abandoned.
- `overrun`  out  1  one-cycle pulse when a tick arrives while `busy`.

## Operation
- **Tick counter:** counts 0..`SAMPLE_DIV`-1 while `enable` is high and wraps. The tick fires in the cycle where the count equals `SAMPLE_DIV`-1.
- **FSM states:** IDLE, REQ, GAP.
  - **IDLE:** on tick, go to REQ. Set byte index to 0 and `rd_addr` to `BASE_ADDR`.
  - **REQ:** `rd_req` = 1. When `rd_ack` is sampled high:
    - store `rd_data` into shadow byte[idx];
    - if idx = 5, go to IDLE and publish;
    - otherwise idx++, `rd_addr` = `BASE_ADDR` + idx, go to GAP.
  - **GAP:** one cycle with `rd_req` = 0, then return to REQ.
- **Publish:** on the same edge, drive `data_x` = {byte1, byte0}, `data_y` = {byte3, byte2}, `data_z` = {byte5, byte4}, and pulse `sample_valid`. Bytes are little-endian, low byte first; the word is two's complement with no sign manipulation.
- **Timeout:** a wait counter is cleared on entering REQ and increments each cycle in REQ without `rd_ack`. When it reaches `TIMEOUT`-1 without ack:
  - drop `rd_req`, pulse `timeout_err`, go to IDLE;
  - shadow bytes are discarded and the outputs keep their previous sample.
- **Ack arbitration:** `rd_ack` is ignored unless state = REQ. If ack and the timeout expiry coincide, the ack wins.
- **Overrun:** a tick while `busy` pulses `overrun` and is dropped; the current fetch continues.
- **enable low:** an in-progress fetch still completes or times out. Only new ticks are suppressed.
- **Reset:** all outputs go to 0, FSM to IDLE, and all counters and shadow bytes are cleared. Asserting reset mid-fetch drops `rd_req` immediately and publishes nothing.

## Timing
- First `rd_req` is high in the cycle after the tick.
- `rd_req` is low in the cycle after an accepted ack, which is the GAP cycle.
- `sample_valid` and the new data appear in the cycle after the sixth ack.
- Zero-wait slave (ack in the first REQ cycle): tick-to-`sample_valid` = 12 cycles, made up of 6 REQ + 5 GAP + 1.
- `timeout_err` is high in the cycle after the timeout expiry, with `rd_req` low in that same cycle.
- All outputs are registered; there are no combinational paths from input to output.

## Structure
- Shared package `joystick_pkg` holds:
  - the FSM state enum;
  - `AXIS_BYTES` = 6;
  - default `BASE_ADDR` (8'h32);
  - the axis word width (16).
- Sub-module `sample_tick_gen`: the `SAMPLE_DIV` divider with `enable` input and one-cycle `tick` output, reusable by other pollers.
- The sequencer FSM, wait counter and shadow registers live in `axis_sample_sequencer`.

## Test plan
- **Zero-wait slave:** bytes 0x34, 0x12, 0xFE, 0xFF, 0x00, 0x80 → `data_x`=16'h1234, `data_y`=-2, `data_z`=16'h8000, `sample_valid` 12 cycles after the tick, addresses 0x32..0x37 in order.
- **Slave with 3-cycle ack latency:** `rd_addr` is stable during every wait, one GAP cycle appears between bytes, and `sample_valid` arrives 30 cycles after the tick.
- **`TIMEOUT`=8, no ack on byte 3:** `timeout_err` pulses once, `rd_req` drops, outputs keep the prior sample, and the next tick restarts at 0x32.
- **`SAMPLE_DIV`=16 with ack latency 5:** `overrun` pulses on ticks during `busy`, and the in-flight sample still completes correctly.
- **Reset asserted while waiting on byte 4:** `rd_req` and all outputs go to 0 immediately, with no `sample_valid`. After release, the first tick arrives `SAMPLE_DIV` cycles later.
- **Spurious `rd_ack` in IDLE/GAP, and ack coinciding with timeout expiry:** the spurious ack is ignored, and the coincident ack is accepted with no `timeout_err`.
